// File: rtl/debounce_multi_pkg.sv
// Shared defaults and elaboration helpers for the multi-channel debouncer.
package debounce_multi_pkg;

    localparam int unsigned DefNCh        = 4;
    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefThresh     = 50000;
    localparam int unsigned DefHoldW      = 8;
    localparam int unsigned DefHoldThresh = 200;

    // True when value is non-zero and representable in width unsigned bits.
    function automatic bit fits_width(input longint unsigned value, input int unsigned width);
        return (value != 64'd0) && (value < (64'd1 << width));
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, symmetric filter counter, edge pulses and hold detect.
module debounce_chan
    import debounce_multi_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned THRESH      = DefThresh,
    parameter int unsigned HOLD_W      = DefHoldW,
    parameter int unsigned HOLD_THRESH = DefHoldThresh
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic held
);

    if (!fits_width(longint'(THRESH), CNT_W)) begin : gen_bad_thresh
        $error("THRESH must be in 1..2^CNT_W-1");
    end
    if (!fits_width(longint'(HOLD_THRESH), HOLD_W)) begin : gen_bad_hold
        $error("HOLD_THRESH must be in 1..2^HOLD_W-1");
    end

    localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(THRESH - 1);
    localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(HOLD_THRESH);

    logic              sync1;
    logic              s;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [HOLD_W-1:0] hcnt;
    logic [HOLD_W-1:0] hcnt_d;
    logic              dout_d;
    logic              rise_d;
    logic              fall_d;
    logic              held_d;

    always_comb begin
        cnt_d  = cnt;
        dout_d = dout;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == dout) begin
            cnt_d = '0;
        end else if (ce) begin
            if (cnt == CntMax) begin
                dout_d = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end

        hcnt_d = hcnt;
        if (!dout) begin
            hcnt_d = '0;
        end else if (ce && (hcnt != HoldMax)) begin
            hcnt_d = hcnt + HOLD_W'(1);
        end
        // Gating on dout_d makes held drop on the same edge that produces fall.
        held_d = dout_d && (hcnt_d == HoldMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            hcnt  <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            held  <= 1'b0;
        end else begin
            sync1 <= din;
            s     <= sync1;
            cnt   <= cnt_d;
            hcnt  <= hcnt_d;
            dout  <= dout_d;
            rise  <= rise_d;
            fall  <= fall_d;
            held  <= held_d;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel debouncer: independent debounce_chan instances plus a combined event flag.
module debounce_multi
    import debounce_multi_pkg::*;
#(
    parameter int unsigned N_CH        = DefNCh,
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned THRESH      = DefThresh,
    parameter int unsigned HOLD_W      = DefHoldW,
    parameter int unsigned HOLD_THRESH = DefHoldThresh
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] dout,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] held,
    output logic            any_evt
);

    if (N_CH < 1) begin : gen_bad_nch
        $error("N_CH must be at least 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : gen_chan
        debounce_chan #(
            .CNT_W      (CNT_W),
            .THRESH     (THRESH),
            .HOLD_W     (HOLD_W),
            .HOLD_THRESH(HOLD_THRESH)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .din (din[i]),
            .dout(dout[i]),
            .rise(rise[i]),
            .fall(fall[i]),
            .held(held[i])
        );
    end

    assign any_evt = |(rise | fall);

endmodule
